// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write port, registered read port.
// The read register clears on reset; the array itself is never cleared.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store data at wr_addr when enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, holds when not enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with fill level, programmable
// almost flags, overflow/underflow pulses and synchronous flush.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_acc;
    logic          wr_acc;
    logic          mem_we;
    logic          mem_re;

    // Status flags decode straight from the registered fill level
    always_comb begin
        full         = (count == CW'(DEPTH));
        empty        = (count == '0);
        almost_full  = (count >= CW'(AF_LEVEL));
        almost_empty = (count <= CW'(AE_LEVEL));
    end

    // Accept logic: a full FIFO still takes a write if a read frees a slot
    always_comb begin
        rd_acc = rd_en & ~empty;
        wr_acc = wr_en & (~full | rd_acc);
        mem_we = wr_acc & ~flush & ~rst;
        mem_re = rd_acc & ~flush;
    end

    // Pointers, fill level and error pulses; reset beats flush beats traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (mem_re),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_param.sv
// Randomised scoreboard bench for fifo_param against a queue model.
// Directed phases cover reset, overflow, full/empty wr+rd, wrap, flush.
module tb_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state
    int               mq[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_ov = 1'b0;
    logic             m_un = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AFL),
        .AE_LEVEL (AEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: each accepted read owes one data_out value
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            chk("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
    end

    // one clock of stimulus; the model advances on the same edge
    task automatic cycle(input logic w, input logic r, input logic [7:0] d,
                         input logic f, input logic rs);
        bit racc;
        bit wacc;
        int n;
        wr_en = w; rd_en = r; data_in = d; flush = f; rst = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete(); m_dout = '0; m_ov = 0; m_un = 0;
        end else if (f) begin
            mq.delete(); m_ov = 0; m_un = 0;
        end else begin
            racc = r && (mq.size() > 0);
            wacc = w && ((mq.size() < DEPTH) || racc);
            if (racc) begin
                m_dout = WIDTH'(mq.pop_front());
                exp_q.push_back(m_dout);
            end
            if (wacc) mq.push_back(int'(d));
            m_ov = w && !wacc;
            m_un = r && !racc;
        end
        #1;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AFL));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AEL));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
        chk("data_out", 32'(data_out), 32'(m_dout));
    endtask

    initial begin
        logic [7:0] d;
        // reset with a write request pending: nothing may be stored
        cycle(1, 0, 8'hFF, 0, 1);
        cycle(1, 0, 8'hFF, 0, 1);
        cycle(0, 0, 8'h00, 0, 0);
        // fill, overflow, drain
        for (int i = 1; i <= 8; i++) cycle(1, 0, 8'(i * 17), 0, 0);
        cycle(1, 0, 8'h99, 0, 0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        cycle(0, 0, 8'h00, 0, 0);
        chk("ovf_one_cycle", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 8'h00, 0, 0);
        chk("drain_last", 32'(data_out), 32'h88);
        // full with simultaneous wr+rd
        for (int i = 1; i <= 8; i++) cycle(1, 0, 8'(i * 17), 0, 0);
        cycle(1, 1, 8'hAA, 0, 0);
        chk("full_wr_rd_data", 32'(data_out), 32'h11);
        for (int i = 0; i < 8; i++) cycle(0, 1, 8'h00, 0, 0);
        chk("full_drain_tail", 32'(data_out), 32'hAA);
        // empty with simultaneous wr+rd: no fall-through
        cycle(1, 1, 8'h5C, 0, 0);
        chk("empty_wr_rd_un", 32'(underflow), 32'd1);
        cycle(0, 1, 8'h00, 0, 0);
        chk("empty_wr_rd_data", 32'(data_out), 32'h5C);
        // wrap-around bursts
        d = 8'h20;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 3; i++) begin
                cycle(1, 0, d, 0, 0);
                d++;
            end
            for (int i = 0; i < 2; i++) cycle(0, 1, 8'h00, 0, 0);
        end
        // flush at count 5 with both requests
        cycle(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h40 + i), 0, 0);
        cycle(0, 1, 8'h00, 0, 0);
        cycle(1, 0, 8'h50, 0, 0);
        chk("pre_flush_count", 32'(count), 32'd5);
        cycle(1, 1, 8'h77, 1, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_hold", 32'(data_out), 32'h40);
        // reset at count 3
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'(8'h60 + i), 0, 0);
        cycle(0, 1, 8'h00, 0, 0);
        cycle(1, 0, 8'h63, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd3);
        cycle(1, 1, 8'h00, 0, 1);
        chk("rst_dout", 32'(data_out), 32'd0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
        end
        cycle(0, 0, 8'h00, 0, 0);
        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
